// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared types, sizes and index helpers for the 8-point FFT path.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_DW = 16;
    localparam int FFT_N  = 8;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    typedef cplx_t frame_t [FFT_N];

    // Reverses the low 'bits' bits of idx; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) begin
            r[bits-1-i] = idx[i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_collector
// Description : Assembles streamed complex samples into N-sample frames with a
//               per-frame mode, presented as a registered parallel bundle.
//               Build option FFT_COLLECT_BITREV_EN stores frames bit-reversed.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int N  = FFT_N
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DW-1:0]               in_re,
    input  logic [DW-1:0]               in_im,
    input  logic                        in_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [N-1:0][1:0][DW-1:0]   out_frame,
    output logic                        out_mode,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int LG = $clog2(N);
    localparam int CW = LG + 1;

    logic [CW-1:0]              r_count;
    logic                       r_mode;
    logic [N-1:0][1:0][DW-1:0]  r_buf;

    logic                       w_full;
    logic                       w_xfer;
    logic                       w_acc;
    logic [LG-1:0]              w_slot;
    logic [LG-1:0]              w_widx;

    assign w_full   = (r_count == CW'(N));
    assign w_xfer   = w_full && (!out_valid || out_ready);
    assign in_ready = reset && !flush && (!w_full || w_xfer);
    assign w_acc    = in_valid && in_ready;

    // A sample accepted on a transfer edge starts the next frame at slot 0.
    always_comb begin
        w_slot = w_xfer ? '0 : r_count[LG-1:0];
`ifdef FFT_COLLECT_BITREV_EN
        w_widx = LG'(bitrev(32'(w_slot), LG));
`else
        w_widx = w_slot;
`endif
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[w_widx] <= {in_im, in_re};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_mode  <= 1'b0;
        end else begin
            if (w_acc && (r_count == '0 || w_xfer)) begin
                r_mode <= in_mode;
            end
            if (flush) begin
                r_count <= '0;
            end else if (w_xfer) begin
                r_count <= w_acc ? CW'(1) : '0;
            end else if (w_acc) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_frame <= '0;
            out_mode  <= 1'b0;
            out_valid <= 1'b0;
        end else if (w_xfer) begin
            out_frame <= r_buf;
            out_mode  <= r_mode;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_collector
// Description : Directed and random stimulus against a queue-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_collector;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [15:0]            in_re, in_im;
    logic                   in_mode, in_valid, in_ready, flush;
    logic [7:0][1:0][15:0]  out_frame;
    logic                   out_mode, out_valid, out_ready;

    int checks = 0;
    int passes = 0;

    // Reference state: samples collected so far and the presented frame.
    logic [31:0]            coll[$];
    logic                   m_mode;
    logic [7:0][1:0][15:0]  m_frame;
    logic                   m_om, m_ov;
    logic                   last_acc;
    int                     acc_cnt;

    fft_frame_collector dut (
        .clk       (clk),
        .reset     (reset),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_frame (out_frame),
        .out_mode  (out_mode),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int pos(input int k);
`ifdef FFT_COLLECT_BITREV_EN
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        return k;
`endif
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        coll.delete();
        m_mode  = 1'b0;
        m_frame = '0;
        m_om    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im,
                        input logic md, input logic fl, input logic ordy);
        logic full, xfer, rdy;
        @(negedge clk);
        in_valid = v; in_re = re; in_im = im; in_mode = md; flush = fl; out_ready = ordy;
        full = (coll.size() == 8);
        xfer = full && (!m_ov || ordy);
        rdy  = reset && !fl && (!full || xfer);
        #1 chk("in_ready", 256'(in_ready), 256'(rdy));
        last_acc = v && rdy;
        if (last_acc) acc_cnt++;
        @(posedge clk);
        if (xfer) begin
            for (int k = 0; k < 8; k++) m_frame[pos(k)] = coll[k];
            m_om = m_mode;
            m_ov = 1'b1;
            coll.delete();
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (fl) coll.delete();
        if (last_acc) begin
            if (coll.size() == 0) m_mode = md;
            coll.push_back({im, re});
        end
        #1;
        chk("out_valid", 256'(out_valid), 256'(m_ov));
        chk("out_mode", 256'(out_mode), 256'(m_om));
        chk("out_frame", out_frame, m_frame);
    endtask

    initial begin
        reset = 1'b0; in_re = '0; in_im = '0; in_mode = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        acc_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_frame", out_frame, 256'(0));
        chk("rst_out_mode", 256'(out_mode), 256'(0));
        reset = 1'b1;

        // First frame: re = k*0x100, im = -k
        for (int k = 0; k < 8; k++) step(1'b1, 16'(k * 256), 16'(-k), 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid", 256'(out_valid), 256'(1));
        chk("t1_re3", 256'(out_frame[pos(3)][0]), 256'(16'h0300));
        chk("t1_im3", 256'(out_frame[pos(3)][1]), 256'(16'hFFFD));
        chk("t1_mode", 256'(out_mode), 256'(0));
`ifdef FFT_COLLECT_BITREV_EN
        chk("t1_re_slot1", 256'(out_frame[1][0]), 256'(16'h0400));
`else
        chk("t1_re_slot1", 256'(out_frame[1][0]), 256'(16'h0100));
`endif

        // Continuous 24-sample stream
        acc_cnt = 0;
        for (int k = 0; k < 24; k++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
        chk("t2_accepted", 256'(acc_cnt), 256'(24));
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Backpressure: 10 offered while output stalled, 8 accepted
        for (int k = 0; k < 8; k++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
        acc_cnt = 0;
        for (int k = 0; k < 10; k++) step(1'b1, 16'(16'h5000 + k), 16'(k), 1'b0, 1'b0, 1'b0);
        chk("t3_accepted", 256'(acc_cnt), 256'(8));
        chk("t3_stall_ready", 256'(in_ready), 256'(0));
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t3_frame2_re0", 256'(out_frame[0][0]), 256'(16'h5000));

        // Per-frame mode, then flush of a partial frame
        for (int k = 0; k < 8; k++) step(1'b1, 16'($urandom), 16'($urandom), k == 0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_mode", 256'(out_mode), 256'(1));
        for (int k = 0; k < 3; k++) step(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b1, 16'(16'h7000 + k), 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_flush_re0", 256'(out_frame[0][0]), 256'(16'h7000));
        chk("t4_flush_mode", 256'(out_mode), 256'(0));

        // Reset mid-frame
        for (int k = 0; k < 5; k++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("t5_out_valid", 256'(out_valid), 256'(0));
        chk("t5_out_frame", out_frame, 256'(0));
        chk("t5_in_ready", 256'(in_ready), 256'(0));
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t5_clean_valid", 256'(out_valid), 256'(1));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom % 32) == 0, ($urandom % 3) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_collector.md
Name: fft_frame_collector

Overview:
- Upstream stage of the 8-point FFT/IFFT selector.
- Accepts a stream of complex 16-bit samples over a valid/ready handshake and assembles them into complete 8-sample frames.
- Latches the per-frame FFT/IFFT mode and presents each frame plus its mode as a stable parallel bundle with its own valid/ready handshake.
- The bundle feeds the selector's xn/mode inputs.

Parameters:
- DW, 16, sample component width (signed, Q1.15).
- N, 8, samples per frame; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_re  input  DW  sample real part.
- in_im  input  DW  sample imaginary part.
- in_mode  input  1  frame mode (0 = FFT, 1 = IFFT); sampled only with a frame's first sample.
- in_valid  input  1  sample present.
- in_ready  output  1  collector accepts a sample this cycle.
- flush  input  1  synchronous abort of the partial frame.
- out_frame  output  N x 2 x DW  frame; index [k][0] = real, [k][1] = imaginary.
- out_mode  output  1  mode latched for out_frame.
- out_valid  output  1  frame available.
- out_ready  input  1  downstream consumes the frame.

Behaviour:
- Internal state: collect buffer buf[N], count (0..N, width clog2(N)+1), output register, out_valid.
- Accept: in_valid && in_ready at a rising edge.
  - buf[count] <= sample; count <= count+1.
  - If count == 0 (or a transfer occurs this edge), mode_q <= in_mode.
- Transfer condition: count == N && (!out_valid || out_ready).
  - out_frame <= buf; out_mode <= mode_q; out_valid <= 1.
  - count <= 0, or 1 if a sample is accepted the same edge; that sample goes to index 0 of the new frame.
- Consume: out_valid && out_ready with no transfer -> out_valid <= 0.
- out_frame and out_mode are held stable while out_valid && !out_ready.
- in_ready (combinational) = reset && !flush && (count < N || transfer condition).
  - Gives full throughput: one sample per cycle, no bubbles, when out_ready is held 1.
- Latency: last sample accepted at edge k -> out_valid = 1 after edge k+1.
- Backpressure: with the buffer full and the output stalled, in_ready = 0. Samples are never overwritten or dropped.
- flush:
  - Forces in_ready = 0 and count <= 0, discarding the partial or full collected frame.
  - If the transfer condition holds the same cycle, the transfer still happens first and the frame is delivered.
  - The output register and out_valid are untouched.
- Mode is per frame. in_mode on samples 1..N-1 is ignored, so a mode change mid-frame takes effect on the next frame.
- Reset (asynchronous assert, synchronous release):
  - count = 0, mode_q = 0.
  - out_frame all zeros, out_mode = 0, out_valid = 0.
  - in_ready = 0 while reset is low.
- Reset mid-frame: the partial frame is lost; no output is generated.
- Data passes through bit-exact: no scaling, no sign change.

Optional Feature:
- Macro FFT_COLLECT_BITREV_EN.
- Defined: sample k is stored at buf[bitrev(k)] (log2(N) bits), so out_frame is presented in bit-reversed order for a decimation-in-time core. Handshake and latency are unchanged.
- Undefined: natural order, buf[k].

Decomposition:
- Shared package fft_pkg holds:
  - localparams FFT_DW = 16, FFT_N = 8;
  - typedef cplx_t (packed struct re, im, signed [FFT_DW-1:0]);
  - typedef frame_t (cplx_t array [FFT_N]);
  - function bitrev(idx, bits).
- No sub-module; the block is a single counter plus register array with handshake logic.

Test Plan:
- Stream 8 samples (re = k*0x0100, im = -k) with in_mode = 0 on consecutive cycles, out_ready = 1 -> one cycle after the 8th accept: out_valid = 1, out_frame[3] = {0x0300, 0xFFFD}, out_mode = 0.
- Continuous stream of 24 samples, out_ready = 1 -> three frames; in_ready never drops; out_valid pulses every 8 cycles.
- Hold out_ready = 0 after frame 1 and feed 10 more samples -> 8 accepted, then in_ready = 0; out_frame unchanged; out_ready = 1 for one cycle -> frame 2 appears, in_ready returns to 1.
- in_mode = 1 on sample 0 and 0 on samples 1..7 -> out_mode = 1. Then flush after 3 samples of the next frame -> next frame's index 0 equals the first post-flush sample.
- Assert reset low after 5 samples -> out_valid = 0 and out_frame = 0 immediately, in_ready = 0; after release, 8 new samples produce one clean frame.
- With FFT_COLLECT_BITREV_EN defined, feed re = k -> out_frame re = {0,4,2,6,1,5,3,7}.
